// File: rtl/key_cmd_ctrl_if.sv
// Decoded-key strobes in, alarm-clock controls out.
// master = key decoder side, slave = command sequencer.
interface key_cmd_ctrl_if;
    logic        det_esc;
    logic        det_num;
    logic        det_num0to5;
    logic        det_cr;
    logic        det_atSign;
    logic        det_A;
    logic        det_L;
    logic        det_N;
    logic        det_S;
    logic [3:0]  digit;
    logic        run;
    logic        alarm_en;
    logic [1:0]  led_sel;
    logic        busy;
    logic        load_time;
    logic        load_alarm;
    logic [15:0] hhmm;
    logic        err;

    modport master (
        output det_esc, det_num, det_num0to5, det_cr, det_atSign,
               det_A, det_L, det_N, det_S, digit,
        input  run, alarm_en, led_sel, busy, load_time, load_alarm, hhmm, err
    );

    modport slave (
        input  det_esc, det_num, det_num0to5, det_cr, det_atSign,
               det_A, det_L, det_N, det_S, digit,
        output run, alarm_en, led_sel, busy, load_time, load_alarm, hhmm, err
    );
endinterface

// File: rtl/key_cmd_ctrl.sv
// Key command sequencer: run/alarm/LED controls and BCD HH:MM entry with commit pulses.
// Define KEYCTRL_TIMEOUT_EN to abort an idle entry after TIMEOUT_CYC cycles.
module key_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 12_000_000,
    parameter int TO_W        = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    key_cmd_ctrl_if.slave kif
);
    typedef enum logic [2:0] {S_IDLE, S_H10, S_H1, S_M10, S_M1, S_WCR} state_t;

    if (TO_W < 1 || TO_W > 62 || (64'd1 << TO_W) <= 64'(TIMEOUT_CYC) || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("key_cmd_ctrl: TO_W too narrow for TIMEOUT_CYC");
    end

    state_t      state_q, state_d;
    logic        target_q, target_d;   // 0 = time, 1 = alarm
    logic [15:0] shadow_q, shadow_d;
    logic        run_q, run_d;
    logic        alarm_en_q, alarm_en_d;
    logic [1:0]  led_sel_q, led_sel_d;
    logic        busy_q, busy_d;
    logic        load_time_q, load_time_d;
    logic        load_alarm_q, load_alarm_d;
    logic [15:0] hhmm_q, hhmm_d;
    logic        err_q, err_d;

    logic any_key;
    logic dig_ok;
    logic commit;
    logic to_fire;

    assign any_key = kif.det_esc | kif.det_num | kif.det_num0to5 | kif.det_cr |
                     kif.det_atSign | kif.det_A | kif.det_L | kif.det_N | kif.det_S;
    assign commit  = (state_q == S_WCR) && kif.det_cr;

    always_comb begin
        dig_ok = 1'b0;
        unique case (state_q)
            S_H10:   dig_ok = kif.det_num && (kif.digit <= 4'd2);
            S_H1:    dig_ok = kif.det_num &&
                              ((shadow_q[15:12] == 4'd2) ? (kif.digit <= 4'd3) : (kif.digit <= 4'd9));
            S_M10:   dig_ok = kif.det_num && kif.det_num0to5;
            S_M1:    dig_ok = kif.det_num && (kif.digit <= 4'd9);
            default: dig_ok = 1'b0;
        endcase
    end

`ifdef KEYCTRL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Fires on the edge where the count would reach TIMEOUT_CYC-1; a key that cycle wins.
    assign to_fire = busy_q && !any_key && (to_cnt_q == TO_W'(TIMEOUT_CYC - 2));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (any_key || to_fire)
            to_cnt_d = '0;
        else if (busy_q)
            to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            target_q     <= 1'b0;
            shadow_q     <= '0;
            run_q        <= 1'b0;
            alarm_en_q   <= 1'b0;
            led_sel_q    <= '0;
            busy_q       <= 1'b0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            hhmm_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            shadow_q     <= shadow_d;
            run_q        <= run_d;
            alarm_en_q   <= alarm_en_d;
            led_sel_q    <= led_sel_d;
            busy_q       <= busy_d;
            load_time_q  <= load_time_d;
            load_alarm_q <= load_alarm_d;
            hhmm_q       <= hhmm_d;
            err_q        <= err_d;
        end
    end

    // Next state, entry target and shadow digits
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        shadow_d = shadow_q;
        unique case (state_q)
            S_IDLE: begin
                if (kif.det_L) begin
                    target_d = 1'b0;
                    state_d  = S_H10;
                end else if (kif.det_atSign) begin
                    target_d = 1'b1;
                    state_d  = S_H10;
                end
            end
            S_H10: if (dig_ok) begin shadow_d[15:12] = kif.digit; state_d = S_H1;  end
            S_H1:  if (dig_ok) begin shadow_d[11:8]  = kif.digit; state_d = S_M10; end
            S_M10: if (dig_ok) begin shadow_d[7:4]   = kif.digit; state_d = S_M1;  end
            S_M1:  if (dig_ok) begin shadow_d[3:0]   = kif.digit; state_d = S_WCR; end
            S_WCR: if (commit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && (kif.det_esc || to_fire))
            state_d = S_IDLE;
    end

    // Registered outputs
    always_comb begin
        run_d        = run_q;
        alarm_en_d   = alarm_en_q;
        led_sel_d    = led_sel_q;
        hhmm_d       = hhmm_q;
        load_time_d  = 1'b0;
        load_alarm_d = 1'b0;
        err_d        = 1'b0;
        busy_d       = (state_d != S_IDLE);
        if (state_q == S_IDLE) begin
            if (kif.det_S)  run_d      = 1'b1;
            if (kif.det_cr) run_d      = 1'b0;
            if (kif.det_A)  alarm_en_d = ~alarm_en_q;
            if (kif.det_N)  led_sel_d  = led_sel_q + 2'd1;
        end else begin
            err_d = (any_key && !dig_ok && !commit) || to_fire;
            if (commit) begin
                hhmm_d       = shadow_q;
                load_time_d  = ~target_q;
                load_alarm_d = target_q;
            end
        end
    end

    assign kif.run        = run_q;
    assign kif.alarm_en   = alarm_en_q;
    assign kif.led_sel    = led_sel_q;
    assign kif.busy       = busy_q;
    assign kif.load_time  = load_time_q;
    assign kif.load_alarm = load_alarm_q;
    assign kif.hhmm       = hhmm_q;
    assign kif.err        = err_q;
endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Directed + random bench for key_cmd_ctrl against a digit-list reference model.
module tb_key_cmd_ctrl;
    localparam int TO_CYC = 16;
    localparam int K_NONE = 0, K_ESC = 1, K_NUM = 2, K_CR = 3, K_AT = 4,
                   K_A = 5, K_L = 6, K_N = 7, K_S = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_cmd_ctrl_if kif();
    key_cmd_ctrl #(.TIMEOUT_CYC(TO_CYC), .TO_W(5)) dut (.clk(clk), .rst_n(rst_n), .kif(kif));

    int n_chk = 0;
    int n_fail = 0;

    bit          m_run, m_al, m_ent, m_tgt;
    int          m_led, m_n, m_idle;
    int          m_d[4];
    logic [15:0] m_hhmm;
    bit          e_lt, e_la, e_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_al = 0; m_ent = 0; m_tgt = 0;
        m_led = 0; m_n = 0; m_idle = 0; m_hhmm = '0;
        e_lt = 0; e_la = 0; e_err = 0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
    endtask

    function automatic bit dig_ok(input int n, input int dg);
        case (n)
            0:       return dg <= 2;
            1:       return (m_d[0] == 2) ? (dg <= 3) : (dg <= 9);
            2:       return dg <= 5;
            default: return dg <= 9;
        endcase
    endfunction

    task automatic model(input int k, input int dg);
        e_lt = 0; e_la = 0; e_err = 0;
        if (!m_ent) begin
            m_idle = 0;
            case (k)
                K_S:  m_run = 1;
                K_CR: m_run = 0;
                K_A:  m_al = !m_al;
                K_N:  m_led = (m_led + 1) % 4;
                K_L:  begin m_ent = 1; m_tgt = 0; m_n = 0; end
                K_AT: begin m_ent = 1; m_tgt = 1; m_n = 0; end
                default: ;
            endcase
        end else if (k == K_NONE) begin
`ifdef KEYCTRL_TIMEOUT_EN
            m_idle++;
            if (m_idle == TO_CYC - 1) begin e_err = 1; m_ent = 0; m_idle = 0; end
`endif
        end else begin
            m_idle = 0;
            if (k == K_ESC) begin
                e_err = 1; m_ent = 0;
            end else if (m_n < 4 && k == K_NUM && dig_ok(m_n, dg)) begin
                m_d[m_n] = dg; m_n++;
            end else if (m_n == 4 && k == K_CR) begin
                m_hhmm = 16'((m_d[0] << 12) | (m_d[1] << 8) | (m_d[2] << 4) | m_d[3]);
                if (m_tgt) e_la = 1; else e_lt = 1;
                m_ent = 0;
            end else begin
                e_err = 1;
            end
        end
    endtask

    task automatic drive(input int k, input int dg);
        kif.det_esc     = (k == K_ESC);
        kif.det_num     = (k == K_NUM);
        kif.det_num0to5 = (k == K_NUM) && (dg <= 5);
        kif.det_cr      = (k == K_CR);
        kif.det_atSign  = (k == K_AT);
        kif.det_A       = (k == K_A);
        kif.det_L       = (k == K_L);
        kif.det_N       = (k == K_N);
        kif.det_S       = (k == K_S);
        kif.digit       = 4'(dg);
    endtask

    task automatic check_all(input string where);
        chk({where, ".run"},        16'(kif.run),        16'(m_run));
        chk({where, ".alarm_en"},   16'(kif.alarm_en),   16'(m_al));
        chk({where, ".led_sel"},    16'(kif.led_sel),    16'(m_led));
        chk({where, ".busy"},       16'(kif.busy),       16'(m_ent));
        chk({where, ".load_time"},  16'(kif.load_time),  16'(e_lt));
        chk({where, ".load_alarm"}, 16'(kif.load_alarm), 16'(e_la));
        chk({where, ".hhmm"},       kif.hhmm,            m_hhmm);
        chk({where, ".err"},        16'(kif.err),        16'(e_err));
    endtask

    task automatic step(input int k, input int dg);
        @(negedge clk);
        drive(k, dg);
        model(k, dg);
        @(posedge clk);
        #1;
        check_all("step");
        drive(K_NONE, 0);
    endtask

    initial begin
        drive(K_NONE, 0);
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // simple IDLE controls, back-to-back
        step(K_S, 0);   chk("run_on", 16'(kif.run), 16'd1);
        step(K_N, 0); step(K_N, 0); step(K_N, 0);
        chk("led3", 16'(kif.led_sel), 16'd3);
        step(K_N, 0);   chk("led_wrap", 16'(kif.led_sel), 16'd0);
        step(K_A, 0);
        step(K_CR, 0);  chk("run_off", 16'(kif.run), 16'd0);
        step(K_ESC, 0); step(K_NUM, 7);

        // time entry 12:34
        step(K_L, 0);   chk("busy_after_l", 16'(kif.busy), 16'd1);
        step(K_NUM, 1); step(K_NUM, 2); step(K_NUM, 3); step(K_NUM, 4);
        step(K_CR, 0);
        chk("lt_1234", 16'(kif.load_time), 16'd1);
        chk("hhmm_1234", kif.hhmm, 16'h1234);

        // alarm entry with rejected H1 digit, then 23:59
        step(K_AT, 0); step(K_NUM, 2);
        step(K_NUM, 4); chk("err_h1_gt3", 16'(kif.err), 16'd1);
        step(K_NUM, 3); step(K_NUM, 5); step(K_NUM, 9); step(K_CR, 0);
        chk("la_2359", kif.hhmm, 16'h2359);

        // M10 > 5 rejected, then ESC abort
        step(K_L, 0); step(K_NUM, 0); step(K_NUM, 9);
        step(K_NUM, 6); chk("err_m10", 16'(kif.err), 16'd1);
        step(K_S, 0);   step(K_CR, 0);
        step(K_ESC, 0); chk("esc_idle", 16'(kif.busy), 16'd0);
        chk("esc_keep_hhmm", kif.hhmm, 16'h2359);

        // randomized key stream
        for (int i = 0; i < 600; i++) begin
            int r, k, dg;
            r = int'($urandom_range(0, 99));
            dg = int'($urandom_range(0, 9));
            if      (r < 45) k = K_NUM;
            else if (r < 55) k = K_CR;
            else if (r < 60) k = K_ESC;
            else if (r < 69) k = K_L;
            else if (r < 76) k = K_AT;
            else if (r < 82) k = K_S;
            else if (r < 87) k = K_A;
            else if (r < 92) k = K_N;
            else             k = K_NONE;
            step(k, dg);
        end
        step(K_ESC, 0);

`ifdef KEYCTRL_TIMEOUT_EN
        step(K_L, 0); step(K_NUM, 1);
        repeat (TO_CYC - 2) step(K_NONE, 0);
        chk("to_still_busy", 16'(kif.busy), 16'd1);
        step(K_NONE, 0);
        chk("to_err", 16'(kif.err), 16'd1);
        chk("to_idle", 16'(kif.busy), 16'd0);
        step(K_L, 0); step(K_NUM, 1);
        repeat (TO_CYC - 2) step(K_NONE, 0);
        step(K_NUM, 2);
        chk("to_key_wins", 16'(kif.busy), 16'd1);
        chk("to_key_no_err", 16'(kif.err), 16'd0);
        step(K_ESC, 0);
`endif

        // async reset while waiting for CR
        step(K_S, 0);
        step(K_L, 0); step(K_NUM, 2); step(K_NUM, 1); step(K_NUM, 4); step(K_NUM, 0);
        chk("wcr_busy", 16'(kif.busy), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(K_CR, 0);
        chk("rst_no_load", 16'(kif.load_time), 16'd0);
        chk("rst_hhmm", kif.hhmm, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_cmd_ctrl.md
# key_cmd_ctrl

Command sequencer that sits between the UART key decoder and the alarm-clock datapath. Consumes one-cycle decoded-key strobes and runs a small command state machine. Simple keys issue run/stop, alarm-enable and LED-select controls. Multi-key entry sequences collect a BCD HH:MM value, range-check each digit, and commit it to the time or alarm registers with a one-cycle load pulse.

## Interface
- TIMEOUT_CYC, default 12_000_000: idle cycles allowed between keys during entry before auto-abort (1 s at 12 MHz); only used with the timeout feature.
- TO_W, default 24: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S  in  1 each  decoded-key strobes.
  - High for exactly one cycle per received character.
  - At most one key class per cycle, except det_num0to5 always arrives together with det_num.
- digit  in  4  low nibble of the received character; meaningful only when det_num=1.
- run  out  1  clock run enable (level).
- alarm_en  out  1  alarm armed (level).
- led_sel  out  2  selected LED display source (level).
- busy  out  1  high while an entry sequence is in progress (any state other than IDLE).
- load_time  out  1  one-cycle pulse: commit hhmm to the time-of-day registers.
- load_alarm  out  1  one-cycle pulse: commit hhmm to the alarm registers.
- hhmm  out  16  BCD {H10,H1,M10,M1}; holds its value between loads.
- err  out  1  one-cycle pulse on a rejected key or an abort.

## Operation
States: IDLE, H10, H1, M10, M1, WCR. A 1-bit target register records whether the entry is for TIME or ALARM.

IDLE:
- 's'/'S': run←1.
- CR: run←0.
- 'a'/'A': alarm_en toggles.
- 'n'/'N': led_sel←led_sel+1, wrapping 3→0.
- 'l'/'L': target←TIME, go to H10.
- '@': target←ALARM, go to H10.
- ESC, digits: ignored, no err.

Entry states (each accepted digit is latched into a shadow register, then the FSM advances):
- H10: accepts digit 0–2.
- H1: accepts 0–9 when H10<2; accepts 0–3 when H10=2.
- M10: accepts only when det_num0to5=1.
- M1: accepts 0–9, then go to WCR.
- WCR: CR copies the shadow register to hhmm and pulses load_time or load_alarm according to target, then returns to IDLE.

Rejection and abort:
- Any other key in an entry state: err pulse; state and shadow register unchanged.
- ESC in any entry state: err pulse, return to IDLE, hhmm unchanged, no load pulse.
- Entry keys never change run, alarm_en or led_sel.
- No digit overwrite or backspace; ESC is the only way out.

## Timing
- All outputs are registered. Key strobe in cycle N → state, level outputs and pulses valid in cycle N+1.
- load_time and load_alarm are never high together.
- On a commit, hhmm updates in the same cycle as the load pulse.
- err is never asserted in the same cycle as a load pulse.
- Back-to-back strobes on consecutive cycles are each processed; no key is dropped.
- Reset values: state IDLE, target TIME, run=0, alarm_en=0, led_sel=0, busy=0, load_time=0, load_alarm=0, err=0, hhmm=16'h0000, shadow register 0.
- Reset asserted mid-entry returns immediately (asynchronously) to IDLE. Partial digits are discarded; no pulse is emitted.

## Configuration
- KEYCTRL_TIMEOUT_EN defined: a TO_W-bit counter clears on any key strobe and on entering H10. It increments every cycle while busy=1.
  - When it reaches TIMEOUT_CYC−1: err pulse, return to IDLE, counter clears.
  - A key arriving in the same cycle as the timeout wins: the key is processed and the counter clears.
- KEYCTRL_TIMEOUT_EN undefined: no counter is instantiated, and entry states wait indefinitely. TIMEOUT_CYC and TO_W are unused.

## Test plan
- Reset, then 's', 'n','n','n','n', 'a', CR → run goes 1 then back to 0; led_sel steps 1,2,3,0; alarm_en=1; err never pulses.
- 'l','1','2','3','4',CR → busy high from the cycle after 'l' until the commit; load_time pulses once with hhmm=16'h1234; load_alarm stays 0.
- '@','2','4' → err pulse on '4'. Then '3','5','9',CR → load_alarm with hhmm=16'h2359.
- 'l','0','9','6' → err pulse on '6' (M10>5). Then ESC → err pulse, IDLE, hhmm keeps its previous value, no load pulse.
- With KEYCTRL_TIMEOUT_EN and TIMEOUT_CYC=16: 'l','1', then silence → err pulse and busy=0 exactly 16 cycles after the '1' strobe. A key at cycle 15 instead keeps the entry alive.
- Assert rst_n=0 during WCR, then deassert and send CR → no load pulse, run=0, all outputs at reset values.
